vec_round_engine: RTL and testbench

- Parametrised successor of the fixed 8x8-bit vector execute stage.
- Applies one lane-wise operation to a LANES x LANE_W vector for a programmable number of rounds. The operation is rotate, add-constant, subtract-constant or XOR-key.
- Operand constants live in runtime-writable config registers.
- Sits between vector register read and writeback, with valid/ready handshakes on both sides.

---
 rtl/vec_pkg.sv | 30 +++
 rtl/vec_round_lane.sv | 35 +++
 rtl/vec_round_engine.sv | 122 ++++++++++++
 tb/tb_vec_round_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types and constants for the vector round engine: opcodes, FSM states
// and config register addresses.
package vec_pkg;

  typedef enum logic [2:0] {
    PASS = 3'd0,
    ROL  = 3'd1,
    ROR  = 3'd2,
    ADD  = 3'd3,
    SUB  = 3'd4,
    XOR  = 3'd5,
    RSV6 = 3'd6,
    RSV7 = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CFG_SHAMT = 0;
  localparam int CFG_XKEY  = 1;
  localparam int CFG_ADDC0 = 2;

  function automatic logic is_reserved(input op_e op);
    return (op == RSV6) || (op == RSV7);
  endfunction

endpackage

// File: rtl/vec_round_lane.sv
// One lane, one round: applies the selected operation to a single LANE_W-bit
// element. Disabled lanes and reserved opcodes pass the input through.
module vec_round_lane
  import vec_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] din,
  input  op_e               op,
  input  logic              en,
  input  logic [LANE_W-1:0] shamt,
  input  logic [LANE_W-1:0] xkey,
  input  logic [LANE_W-1:0] addc,
  output logic [LANE_W-1:0] dout
);

  int unsigned sh;

  always_comb begin
    sh   = int'(shamt) % LANE_W;
    dout = din;
    if (en) begin
      case (op)
        // a shift by the full width yields zero, so sh == 0 rotates cleanly
        ROL:     dout = (din << sh) | (din >> (LANE_W - sh));
        ROR:     dout = (din >> sh) | (din << (LANE_W - sh));
        ADD:     dout = din + addc;
        SUB:     dout = din - addc;
        XOR:     dout = din ^ xkey;
        default: dout = din;
      endcase
    end
  end

endmodule

// File: rtl/vec_round_engine.sv
// Multi-round lane-wise vector execute stage with runtime-writable operand
// constants that are snapshotted per operation.
module vec_round_engine
  import vec_pkg::*;
#(
  parameter int                        LANES      = 8,
  parameter int                        LANE_W     = 8,
  parameter int                        RND_W      = 4,
  parameter logic [LANES*LANE_W-1:0]   ADD_INIT   = 64'hEE43_9ADB_03C9_F70D,
  parameter int                        SHAMT_INIT = 3,
  parameter logic [LANE_W-1:0]         XKEY_INIT  = 8'hAC,
  localparam int                       AW         = $clog2(LANES + 2),
  localparam int                       VW         = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VW-1:0]     in_vec,
  input  logic [2:0]        in_op,
  input  logic [RND_W-1:0]  in_rounds,
  input  logic [LANES-1:0]  in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VW-1:0]     out_vec,
  output logic              out_err,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [LANE_W-1:0] cfg_wdata
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid, once high, holds out_vec and
  // out_err stable until the edge where out_ready is also high.

  state_e             state;
  logic [VW-1:0]      work, next_work;
  logic [VW-1:0]      addc, sh_addc;
  logic [LANE_W-1:0]  shamt, xkey, sh_shamt, sh_xkey;
  op_e                op_q;
  logic [LANES-1:0]   mask_q;
  logic [RND_W-1:0]   cnt;
  int                 cfg_idx;

  assign cfg_idx = int'(cfg_addr);
  assign out_vec = work;

  always_ff @(posedge clk) begin
    if (rst) begin
      shamt <= LANE_W'(SHAMT_INIT);
      xkey  <= XKEY_INIT;
      addc  <= ADD_INIT;
    end else if (cfg_we) begin
      if (cfg_idx == CFG_SHAMT) shamt <= cfg_wdata;
      if (cfg_idx == CFG_XKEY)  xkey  <= cfg_wdata;
      for (int i = 0; i < LANES; i++)
        if (cfg_idx == CFG_ADDC0 + i) addc[i*LANE_W +: LANE_W] <= cfg_wdata;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vec_round_lane #(.LANE_W(LANE_W)) u_lane (
      .din   (work[g*LANE_W +: LANE_W]),
      .op    (op_q),
      .en    (mask_q[g]),
      .shamt (sh_shamt),
      .xkey  (sh_xkey),
      .addc  (sh_addc[g*LANE_W +: LANE_W]),
      .dout  (next_work[g*LANE_W +: LANE_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      work      <= '0;
      op_q      <= PASS;
      mask_q    <= '0;
      cnt       <= '0;
      sh_shamt  <= '0;
      sh_xkey   <= '0;
      sh_addc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_vec;
            op_q     <= op_e'(in_op);
            mask_q   <= in_mask;
            cnt      <= in_rounds;
            sh_shamt <= shamt;
            sh_xkey  <= xkey;
            sh_addc  <= addc;
            out_err  <= is_reserved(op_e'(in_op));
            in_ready <= 1'b0;
            state    <= (in_rounds == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          work <= next_work;
          cnt  <= cnt - RND_W'(1);
          if (cnt == RND_W'(1)) state <= DONE;
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE
          out_valid <= 1'b1;
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_round_engine.sv
// Randomised bench for vec_round_engine against a lane-by-lane arithmetic
// model of the opcodes and config registers.
module tb_vec_round_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_vec;
  logic [2:0]  in_op;
  logic [3:0]  in_rounds;
  logic [7:0]  in_mask;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_vec;
  logic        out_err;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_wdata;

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] exp_q[$];
  logic        exp_err;

  int m_shamt;
  int m_xkey;
  int m_addc[8];

  vec_round_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .in_op     (in_op),
    .in_rounds (in_rounds),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    logic [63:0] init;
    init    = 64'hEE43_9ADB_03C9_F70D;
    m_shamt = 3;
    m_xkey  = 'hAC;
    for (int l = 0; l < 8; l++) m_addc[l] = int'(init[l*8 +: 8]);
  endtask

  task automatic model_cfg(input int addr, input int data);
    if (addr == 0) m_shamt = data;
    else if (addr == 1) m_xkey = data;
    else if (addr >= 2 && addr <= 9) m_addc[addr-2] = data;
  endtask

  function automatic logic [63:0] model(input logic [63:0] v, input int op, input int rnd,
                                        input logic [7:0] msk);
    logic [63:0] r;
    int x, s;
    r = v;
    s = m_shamt % 8;
    for (int l = 0; l < 8; l++) begin
      x = int'(v[l*8 +: 8]);
      if (msk[l]) begin
        for (int k = 0; k < rnd; k++) begin
          case (op)
            1: x = ((x << s) | (x >> (8 - s))) & 255;
            2: x = ((x >> s) | (x << (8 - s))) & 255;
            3: x = (x + m_addc[l]) % 256;
            4: x = (x - m_addc[l] + 256) % 256;
            5: x = x ^ m_xkey;
            default: x = x;
          endcase
        end
      end
      r[l*8 +: 8] = x[7:0];
    end
    return r;
  endfunction

  task automatic cfg_write(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = addr[3:0]; cfg_wdata = data[7:0];
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    model_cfg(addr, data);
  endtask

  // cfg_when: -1 no write, 0 coincident with accept, 1 on the cycle after accept
  task automatic run_op(input logic [63:0] v, input int op, input int rnd, input logic [7:0] msk,
                        input int stall, input int cfg_when, input int ca, input int cd);
    logic [63:0] held;
    int k, w;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    check("ready_before", in_ready, 1);
    exp_q.push_back(model(v, op, rnd, msk));
    exp_err   = (op >= 6);
    in_vec    = v; in_op = op[2:0]; in_rounds = rnd[3:0]; in_mask = msk;
    in_valid  = 1'b1;
    if (cfg_when == 0) begin cfg_we = 1'b1; cfg_addr = ca[3:0]; cfg_wdata = cd[7:0]; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (cfg_when == 0) begin cfg_we = 1'b0; model_cfg(ca, cd); end
    if (cfg_when == 1) begin cfg_we = 1'b1; cfg_addr = ca[3:0]; cfg_wdata = cd[7:0]; end
    check("busy_ready", in_ready, 0);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (cfg_we) begin cfg_we = 1'b0; model_cfg(ca, cd); end
    end
    if (cfg_we) begin cfg_we = 1'b0; model_cfg(ca, cd); end
    check("latency", k, rnd + 1);
    held = out_vec;
    out_ready = 1'b0;
    repeat (stall) @(negedge clk);
    if (stall > 0) begin
      check("stall_vec", out_vec, held);
      check("stall_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
    end
    check("out_vec", out_vec, exp_q.pop_front());
    check("out_err", out_err, exp_err);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_ready", in_ready, 1);
    check("post_valid", out_valid, 0);
  endtask

  initial begin
    logic [63:0] v;
    int saw;
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_op = '0; in_rounds = '0; in_mask = '0;
    out_ready = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_vec", out_vec, 0);

    v = {$urandom, $urandom}; v[7:0] = 8'h81;
    run_op(v, 1, 1, 8'hFF, 0, -1, 0, 0);
    v[7:0] = 8'hF5;
    run_op(v, 3, 1, 8'hFF, 0, -1, 0, 0);
    run_op(v, 3, 1, 8'hFE, 0, -1, 0, 0);

    run_op(64'h0, 5, 3, 8'hFF, 0, 1, 1, 0);
    run_op(64'h0, 5, 1, 8'hFF, 0, -1, 0, 0);
    cfg_write(1, 'h3C);
    run_op(64'h1122334455667788, 5, 2, 8'hFF, 0, -1, 0, 0);
    run_op(64'h1122334455667788, 5, 0, 8'hFF, 0, -1, 0, 0);

    run_op({$urandom, $urandom}, 2, 5, 8'hFF, 5, -1, 0, 0);
    run_op({$urandom, $urandom}, 4, 2, 8'hA5, 0, -1, 0, 0);

    run_op({$urandom, $urandom}, 3, 1, 8'hFF, 0, 0, 2, 'h55);
    run_op({$urandom, $urandom}, 3, 1, 8'hFF, 0, -1, 0, 0);
    cfg_write(12, 'h99);
    run_op({$urandom, $urandom}, 6, 2, 8'hFF, 0, -1, 0, 0);
    run_op({$urandom, $urandom}, 7, 0, 8'h0F, 1, -1, 0, 0);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) cfg_write($urandom_range(0, 15), $urandom_range(0, 255));
      run_op({$urandom, $urandom}, $urandom_range(0, 7), $urandom_range(0, 15),
             8'($urandom_range(0, 255)), $urandom_range(0, 3),
             int'($urandom_range(0, 2)) - 1, $urandom_range(0, 11), $urandom_range(0, 255));
    end

    cfg_write(0, 5);
    in_vec = {$urandom, $urandom}; in_op = 3'd1; in_rounds = 4'd4; in_mask = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    saw = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) saw = 1;
      @(negedge clk);
    end
    check("rst_mid_no_valid", saw, 0);
    check("rst_mid_ready", in_ready, 1);
    run_op(64'h0101010101010101, 1, 1, 8'hFF, 0, -1, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
